// File: rtl/seg7_scan_if.sv
// seg7_scan_if: input word, masks and enable toward the scanner,
// anode/segment drive back out to the board.
interface seg7_scan_if;
  logic        en;
  logic [31:0] din;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic [7:0]  an_n;
  logic [7:0]  seg_n;

  modport master (
    output en, din, dp_mask, blink_mask,
    input  an_n, seg_n
  );

  modport slave (
    input  en, din, dp_mask, blink_mask,
    output an_n, seg_n
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed seven-segment driver with
// frame-latched input, dead-time gaps and per-digit blink.
module seg7_scan #(
  parameter int DWELL      = 1,
  parameter int GAP        = 1,
  parameter int BLINK_HALF = 250
) (
  input logic        clk_1khz,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  typedef enum logic {S_GAP, S_SHOW} state_t;

  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);
  localparam logic [CW-1:0] DWL_END = CW'(DWELL - 1);
  localparam logic [BW-1:0] BLK_END = BW'(BLINK_HALF - 1);

  state_t        state_q, state_d;
  logic          go_show, go_gap;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [31:0]   shadow_q;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;
  logic [7:0]    an_q, seg_q;
  logic [3:0]    code;
  logic [7:0]    pat;

  function automatic logic [6:0] seg_pat(input logic [3:0] c);
    case (c)
      4'h0:    seg_pat = 7'h3F;
      4'h1:    seg_pat = 7'h06;
      4'h2:    seg_pat = 7'h5B;
      4'h3:    seg_pat = 7'h4F;
      4'h4:    seg_pat = 7'h66;
      4'h5:    seg_pat = 7'h6D;
      4'h6:    seg_pat = 7'h7D;
      4'h7:    seg_pat = 7'h07;
      4'h8:    seg_pat = 7'h7F;
      4'h9:    seg_pat = 7'h6F;
      4'hA:    seg_pat = 7'h77;
      4'hB:    seg_pat = 7'h7C;
      4'hC:    seg_pat = 7'h39;
      4'hD:    seg_pat = 7'h5E;
      4'hE:    seg_pat = 7'h40;
      default: seg_pat = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) state_q <= S_GAP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go_show = 1'b0;
    go_gap  = 1'b0;
    case (state_q)
      S_GAP: if (cnt_q == GAP_END) begin
        state_d = S_SHOW;
        go_show = 1'b1;
      end
      S_SHOW: if (cnt_q == DWL_END) begin
        state_d = S_GAP;
        go_gap  = 1'b1;
      end
      default: state_d = S_GAP;
    endcase
  end

  // digit 0 reads din live so it matches the word latched on this edge
  always_comb begin
    code = (idx_q == 3'd0) ? bus.din[3:0]
                           : shadow_q[{idx_q, 2'b00} +: 4];
    pat  = {bus.dp_mask[idx_q], seg_pat(code)};
    if (bus.blink_mask[idx_q] && blink_q) pat = 8'h00;
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'hFFFF_FFFF;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      cnt_q <= (go_show || go_gap) ? '0 : cnt_q + 1'b1;
      if (bcnt_q == BLK_END) begin
        bcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (go_show) begin
        if (idx_q == 3'd0) shadow_q <= bus.din;
        if (bus.en) begin
          an_q  <= ~(8'h01 << idx_q);
          seg_q <= ~pat;
        end else begin
          an_q  <= 8'hFF;
          seg_q <= 8'hFF;
        end
      end
      if (go_gap) begin
        an_q  <= 8'hFF;
        seg_q <= 8'hFF;
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  assign bus.an_n  = an_q;
  assign bus.seg_n = seg_q;
endmodule
